hazard_fwd_unit: RTL and testbench
==================================

# hazard_fwd_unit

Parametrised hazard, forwarding and flush controller for the pipelined MIPS data path. It replaces the ad-hoc branch and PCSrc gating in the current data path. It keeps its own scoreboard of the instructions in EX..WB and drives four things: load-use stalls, the ALU operand forwarding selects, branch squash signals, and two saturating event counters. It sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers and sends control to their enable and clear inputs.

## Interface
- DEPTH, 3: number of scoreboard slots after ID (slot 1 = EX, 2 = MEM, 3 = WB). Range 2..7.
- REG_ADDR_W, 5: register address width.
- LOAD_READY, 3: first slot whose load data is forwardable. Range 2..DEPTH.
- BR_STAGE, 2: slot in which branch_taken is resolved. Range 2..DEPTH.
- CNT_W, 16: width of each event counter.
- SEL_W: derived as clog2(DEPTH+1).

Ports:
- Clk  in  1  clock. All state updates on the rising edge.
- Reset  in  1  asynchronous, active-high. Clears all state.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  REG_ADDR_W  ID source registers.
- id_uses_rs, id_uses_rt  in  1  ID instruction actually reads rs / rt.
- id_reg_write  in  1  ID instruction writes the register file.
- id_mem_read  in  1  ID instruction is a load.
- id_dst  in  REG_ADDR_W  decoded destination (rt, rd or 31).
- branch_taken  in  1  the instruction in slot BR_STAGE redirects the PC.
- stall  out  1  hold PC and IF/ID; insert a bubble into ID/EX.
- flush_ifid  out  1  clear IF/ID on the next edge.
- flush_idex  out  1  insert a bubble into ID/EX on the next edge.
- kill  out  DEPTH  when bit k-1 is set, the instruction in slot k loses its control bits as it advances.
- fwd_a_sel, fwd_b_sel  out  SEL_W  operand source for the EX instruction: 0 = register file, k = slot k result.
- stall_count, flush_count  out  CNT_W  saturating event counters.

## Operation
- **Scoreboard.** Each slot k holds {valid, reg_write, mem_read, dst}. An EX shadow holds the source registers and use bits of the instruction in EX.
- **Advance.** Every edge, slot k moves to slot k+1 and slot DEPTH retires.
  - Slot 1 loads the ID fields, or a bubble (all zero) if stall or flush_idex is high.
  - The EX shadow loads alongside slot 1, or zeros if a bubble is inserted.
- **Load-use stall (combinational).**
  - stall = id_valid, and some slot k with 1 ≤ k ≤ LOAD_READY−2 is valid with mem_read=1 and dst≠0, and dst matches id_rs (with id_uses_rs) or id_rt (with id_uses_rt).
  - Stall holds the ID instruction; it never kills it.
- **Forwarding (combinational).**
  - fwd_a_sel = the smallest k in 2..DEPTH where slot k is valid, reg_write=1, dst≠0, dst = EX rs and EX uses rs. Otherwise 0.
  - fwd_b_sel follows the same rule against rt.
  - The youngest producer always wins.
  - Register $0 never forwards and never stalls.
- **Branch flush (combinational, from branch_taken).**
  - flush_ifid=1 and flush_idex=1.
  - kill[k-1]=1 for 1 ≤ k ≤ BR_STAGE−1; all other kill bits are 0.
  - On the edge, the affected slots advance as bubbles.
  - The branch instruction itself is not killed.
- **Priority.** Flush beats stall. When branch_taken=1, stall is forced to 0 and the ID instruction is squashed.
- **Counters.**
  - stall_count increments on each edge where stall=1.
  - flush_count increments on each edge where branch_taken=1.
  - Both saturate at all-ones and never wrap.
- **Register file.** Write-before-read within a cycle. No slot DEPTH+1 bypass is needed.

## Timing
- **Reset.**
  - Asynchronous: all slots invalid, EX shadow zero, counters zero.
  - While Reset=1: stall, flush_ifid, flush_idex and kill are forced to 0, and fwd selects read 0.
- **Deassertion.** First normal edge is the first Clk rise after Reset falls.
- **Latency.** Outputs are valid the same cycle as their inputs (combinational from registered state plus ID inputs). State updates one edge later.
- **Stall length.** A load-use stall lasts LOAD_READY−1−k cycles, where k is the load's slot; the default is 1 cycle. After the stall the consumer reaches EX with fwd_sel = LOAD_READY.
- **Reset mid-stall or mid-flush.** Everything clears immediately; no partial bubble persists.
- **Back-to-back branches.** Both flushes counted; a killed younger branch never asserts branch_taken (the data path gates it).

## Test plan
All cases use default parameters.
- **Reset.** Reset mid-run with slots full → all outputs 0 immediately; counters 0 after release.
- **ALU chain.** add $3,$1,$2 then sub $4,$3,$1 → sub in EX: fwd_a_sel=2, fwd_b_sel=0. One NOP between → fwd_a_sel=3.
- **Load-use.** lw $4,0($1) then add $5,$4,$4 → stall=1 for exactly 1 cycle, then fwd_a_sel=fwd_b_sel=3; stall_count=1.
- **$0 and unused operands.** lw $0 followed by a reader of $0, and an addi whose id_rt matches the load dst with id_uses_rt=0 → stall=0, fwd=0.
- **Branch.** branch_taken=1 for one cycle → flush_ifid=flush_idex=1, kill=3'b001; next cycle slots 1 and 2 invalid; flush_count=1.
- **Stall plus flush.** branch_taken=1 in the same cycle as a load-use condition → stall=0, flush asserted, stall_count unchanged. Saturation: preload counters to all-ones → stay at 16'hFFFF.

Source files
------------

// File: rtl/hazard_fwd_unit.sv
// Hazard, forwarding and branch-flush controller for the pipelined MIPS data path.
// Keeps a small scoreboard of EX..WB and drives load-use stalls, ALU forward selects, squash and event counters.
module hazard_fwd_unit #(
  parameter int  DEPTH      = 3,
  parameter int  REG_ADDR_W = 5,
  parameter int  LOAD_READY = 3,
  parameter int  BR_STAGE   = 2,
  parameter int  CNT_W      = 16,
  localparam int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic [REG_ADDR_W-1:0] id_dst,
  input  logic                  branch_taken,
  output logic                  stall,
  output logic                  flush_ifid,
  output logic                  flush_idex,
  output logic [DEPTH-1:0]      kill,
  output logic [SEL_W-1:0]      fwd_a_sel,
  output logic [SEL_W-1:0]      fwd_b_sel,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_read;
    logic [REG_ADDR_W-1:0] dst;
  } slot_t;

  slot_t                 slot_q [1:DEPTH];
  slot_t                 slot_d [1:DEPTH];
  logic [REG_ADDR_W-1:0] ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;
  logic                  ex_use_rs_q, ex_use_rs_d, ex_use_rt_q, ex_use_rt_d;
  logic [CNT_W-1:0]      stall_count_q, stall_count_d, flush_count_q, flush_count_d;
  logic                  load_use;
  logic                  bubble;

  // A slot produces register r for a consumer that actually reads r; $0 is never a real producer.
  function automatic logic hits(slot_t s, logic [REG_ADDR_W-1:0] r, logic used);
    return used && s.valid && (s.dst == r) && (s.dst != '0);
  endfunction

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    load_use = 1'b0;
    for (int k = 1; k <= LOAD_READY - 2; k++) begin
      if (slot_q[k].mem_read &&
          (hits(slot_q[k], id_rs, id_uses_rs) || hits(slot_q[k], id_rt, id_uses_rt)))
        load_use = 1'b1;
    end
    stall      = !Reset && !branch_taken && id_valid && load_use;
    flush_ifid = !Reset && branch_taken;
    flush_idex = flush_ifid;
    kill       = '0;
    for (int k = 1; k <= BR_STAGE - 1; k++) kill[k-1] = flush_ifid;

    fwd_a_sel = '0;
    fwd_b_sel = '0;
    if (!Reset) begin
      // Oldest first, so the youngest matching producer is the last one written.
      for (int k = DEPTH; k >= 2; k--) begin
        if (slot_q[k].reg_write && hits(slot_q[k], ex_rs_q, ex_use_rs_q)) fwd_a_sel = SEL_W'(k);
        if (slot_q[k].reg_write && hits(slot_q[k], ex_rt_q, ex_use_rt_q)) fwd_b_sel = SEL_W'(k);
      end
    end
  end

  always_comb begin
    bubble = stall || flush_idex;
    if (bubble) begin
      slot_d[1]   = '0;
      ex_rs_d     = '0;
      ex_rt_d     = '0;
      ex_use_rs_d = 1'b0;
      ex_use_rt_d = 1'b0;
    end else begin
      slot_d[1].valid     = id_valid;
      slot_d[1].reg_write = id_reg_write;
      slot_d[1].mem_read  = id_mem_read;
      slot_d[1].dst       = id_dst;
      ex_rs_d             = id_rs;
      ex_rt_d             = id_rt;
      ex_use_rs_d         = id_uses_rs;
      ex_use_rt_d         = id_uses_rt;
    end
    for (int k = 2; k <= DEPTH; k++) slot_d[k] = kill[k-2] ? '0 : slot_q[k-1];

    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1)) stall_count_d = stall_count_q + CNT_W'(1);
    flush_count_d = flush_count_q;
    if (flush_ifid && (flush_count_q != '1)) flush_count_d = flush_count_q + CNT_W'(1);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      // NOTE: the scoreboard is a few flops rather than a RAM, so every slot is cleared on reset.
      slot_q        <= '{default: '0};
      ex_rs_q       <= '0;
      ex_rt_q       <= '0;
      ex_use_rs_q   <= 1'b0;
      ex_use_rt_q   <= 1'b0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      // NOTE: non-blocking, so every slot captures its neighbour's pre-edge value.
      slot_q        <= slot_d;
      ex_rs_q       <= ex_rs_d;
      ex_rt_q       <= ex_rt_d;
      ex_use_rs_q   <= ex_use_rs_d;
      ex_use_rt_q   <= ex_use_rt_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: directed pipeline scenarios plus random traffic
// against a history-queue model of the instructions that entered EX.
module tb_hazard_fwd_unit;
  localparam int DEPTH = 3, RW = 5, LOAD_READY = 3, BR_STAGE = 2, CNT_W = 16, SEL_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic          valid, rw, mr, uses_rs, uses_rt;
    logic [RW-1:0] rs, rt, dst;
  } instr_t;

  logic Clk = 1'b0, Reset = 1'b1;
  logic id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, branch_taken;
  logic [RW-1:0] id_rs, id_rt, id_dst;
  logic stall, flush_ifid, flush_idex;
  logic [DEPTH-1:0] kill;
  logic [SEL_W-1:0] fwd_a_sel, fwd_b_sel;
  logic [CNT_W-1:0] stall_count, flush_count;
  logic s_stall, s_flush_ifid, s_flush_idex;
  logic [DEPTH-1:0] s_kill;
  logic [SEL_W-1:0] s_fwd_a, s_fwd_b;
  logic [2:0] s_stall_count, s_flush_count;

  int n_cmp = 0, n_bad = 0;
  instr_t hist[$];          // hist[s-1] is the instruction now in slot s
  int m_stall_cnt, m_flush_cnt;

  always #5 Clk = ~Clk;

  hazard_fwd_unit dut (
    .Clk(Clk), .Reset(Reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_dst(id_dst), .branch_taken(branch_taken),
    .stall(stall), .flush_ifid(flush_ifid), .flush_idex(flush_idex), .kill(kill),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_count(stall_count), .flush_count(flush_count));

  // Narrow counters so saturation is reachable in a few cycles.
  hazard_fwd_unit #(.CNT_W(3)) u_sat (
    .Clk(Clk), .Reset(Reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_dst(id_dst), .branch_taken(branch_taken),
    .stall(s_stall), .flush_ifid(s_flush_ifid), .flush_idex(s_flush_idex), .kill(s_kill),
    .fwd_a_sel(s_fwd_a), .fwd_b_sel(s_fwd_b),
    .stall_count(s_stall_count), .flush_count(s_flush_count));

  function automatic instr_t mk(input logic v, rw, mr, urs, urt, input int rs, rt, dst);
    instr_t i;
    i.valid = v; i.rw = rw; i.mr = mr; i.uses_rs = urs; i.uses_rt = urt;
    i.rs = RW'(rs); i.rt = RW'(rt); i.dst = RW'(dst);
    return i;
  endfunction

  task automatic drive(input instr_t i, input logic br);
    id_valid = i.valid; id_reg_write = i.rw; id_mem_read = i.mr;
    id_uses_rs = i.uses_rs; id_uses_rt = i.uses_rt;
    id_rs = i.rs; id_rt = i.rt; id_dst = i.dst; branch_taken = br;
  endtask

  task automatic tick;
    @(negedge Clk);
  endtask

  task automatic do_reset;
    drive('0, 1'b0);
    Reset = 1'b1;
    tick;
    Reset = 1'b0;
    hist = {};
    for (int s = 0; s < DEPTH; s++) hist.push_back('0);
    m_stall_cnt = 0;
    m_flush_cnt = 0;
  endtask

  // ---------------- reference model ----------------
  function automatic logic m_stall(input instr_t i, input logic br);
    if (br || !i.valid) return 1'b0;
    for (int s = 1; s <= LOAD_READY - 2; s++) begin
      if (hist[s-1].valid && hist[s-1].mr && hist[s-1].dst != 0 &&
          ((i.uses_rs && hist[s-1].dst == i.rs) || (i.uses_rt && hist[s-1].dst == i.rt)))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int m_fwd(input logic [RW-1:0] r, input logic used);
    if (!used || r == 0) return 0;
    for (int s = 2; s <= DEPTH; s++)
      if (hist[s-1].valid && hist[s-1].rw && hist[s-1].dst == r) return s;
    return 0;
  endfunction

  function automatic void m_advance(input instr_t i, input logic br, input logic st);
    if (st && m_stall_cnt < CNT_MAX) m_stall_cnt++;
    if (br && m_flush_cnt < CNT_MAX) m_flush_cnt++;
    if (br) for (int s = 1; s <= BR_STAGE - 1; s++) hist[s-1] = '0;
    hist.push_front((st || br) ? instr_t'('0) : i);
    void'(hist.pop_back());
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset;
    drive('0, 1'b1);
    #1;
    n_cmp++; if ({stall, flush_ifid, flush_idex, kill} !== '0) begin n_bad++; $display("FAIL reset_por_ctrl: got %b want 0", {stall, flush_ifid, flush_idex, kill}); end
    n_cmp++; if ({stall_count, flush_count, fwd_a_sel, fwd_b_sel} !== '0) begin n_bad++; $display("FAIL reset_por_state: got %h want 0", {stall_count, flush_count, fwd_a_sel, fwd_b_sel}); end
    do_reset;
    drive(mk(1, 1, 1, 1, 0, 1, 0, 4), 1'b0); tick;
    drive(mk(1, 1, 0, 1, 1, 4, 4, 5), 1'b0); tick;
    tick;
    drive(mk(1, 1, 1, 1, 0, 1, 0, 2), 1'b1);
    #1;
    n_cmp++; if (fwd_a_sel !== 2'd3) begin n_bad++; $display("FAIL reset_prefill_fwd: got %0d want 3", fwd_a_sel); end
    Reset = 1'b1;
    #1;
    n_cmp++; if ({stall, flush_ifid, flush_idex, kill} !== '0) begin n_bad++; $display("FAIL reset_mid_ctrl: got %b want 0", {stall, flush_ifid, flush_idex, kill}); end
    n_cmp++; if ({fwd_a_sel, fwd_b_sel} !== '0) begin n_bad++; $display("FAIL reset_mid_fwd: got %b want 0", {fwd_a_sel, fwd_b_sel}); end
    n_cmp++; if (stall_count !== '0) begin n_bad++; $display("FAIL reset_mid_stall_count: got %0d want 0", stall_count); end
    tick;
    Reset = 1'b0;
    drive('0, 1'b0);
    #1;
    n_cmp++; if ({stall_count, flush_count} !== '0) begin n_bad++; $display("FAIL reset_release_counts: got %h want 0", {stall_count, flush_count}); end
    n_cmp++; if ({fwd_a_sel, fwd_b_sel} !== '0) begin n_bad++; $display("FAIL reset_release_fwd: got %b want 0", {fwd_a_sel, fwd_b_sel}); end
  endtask

  task automatic test_alu_chain;
    do_reset;
    drive(mk(1, 1, 0, 1, 1, 1, 2, 3), 1'b0); tick;   // add $3,$1,$2
    drive(mk(1, 1, 0, 1, 1, 3, 1, 4), 1'b0); tick;   // sub $4,$3,$1
    drive('0, 1'b0);
    #1;
    n_cmp++; if (fwd_a_sel !== 2'd2) begin n_bad++; $display("FAIL alu_adjacent_a: got %0d want 2", fwd_a_sel); end
    n_cmp++; if (fwd_b_sel !== 2'd0) begin n_bad++; $display("FAIL alu_adjacent_b: got %0d want 0", fwd_b_sel); end
    tick;
    drive(mk(1, 1, 0, 1, 1, 1, 2, 3), 1'b0); tick;
    drive('0, 1'b0); tick;
    drive(mk(1, 1, 0, 1, 1, 3, 1, 4), 1'b0); tick;
    drive('0, 1'b0);
    #1;
    n_cmp++; if (fwd_a_sel !== 2'd3) begin n_bad++; $display("FAIL alu_gap_a: got %0d want 3", fwd_a_sel); end
    n_cmp++; if (fwd_b_sel !== 2'd0) begin n_bad++; $display("FAIL alu_gap_b: got %0d want 0", fwd_b_sel); end
  endtask

  task automatic test_load_use;
    do_reset;
    drive(mk(1, 1, 1, 1, 0, 1, 0, 4), 1'b0); tick;   // lw $4,0($1)
    drive(mk(1, 1, 0, 1, 1, 4, 4, 5), 1'b0);         // add $5,$4,$4
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL load_use_stall: got %b want 1", stall); end
    tick;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL load_use_release: got %b want 0", stall); end
    tick;
    drive('0, 1'b0);
    #1;
    n_cmp++; if ({fwd_a_sel, fwd_b_sel} !== {2'd3, 2'd3}) begin n_bad++; $display("FAIL load_use_fwd: got %0d/%0d want 3/3", fwd_a_sel, fwd_b_sel); end
    n_cmp++; if (stall_count !== 16'd1) begin n_bad++; $display("FAIL load_use_count: got %0d want 1", stall_count); end
  endtask

  task automatic test_zero_and_unused;
    do_reset;
    drive(mk(1, 1, 1, 1, 0, 1, 0, 0), 1'b0); tick;   // lw $0
    drive(mk(1, 1, 0, 1, 1, 0, 0, 6), 1'b0);         // reader of $0
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL zero_stall: got %b want 0", stall); end
    tick;
    drive(mk(1, 1, 1, 1, 0, 1, 0, 4), 1'b0);         // lw $4
    #1;
    n_cmp++; if ({fwd_a_sel, fwd_b_sel} !== '0) begin n_bad++; $display("FAIL zero_fwd: got %0d/%0d want 0/0", fwd_a_sel, fwd_b_sel); end
    tick;
    drive(mk(1, 1, 0, 1, 0, 1, 4, 7), 1'b0);         // addi $7,$1 with rt field = $4
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL unused_rt_stall: got %b want 0", stall); end
    tick;
    drive('0, 1'b0);
    #1;
    n_cmp++; if ({fwd_a_sel, fwd_b_sel} !== '0) begin n_bad++; $display("FAIL unused_rt_fwd: got %0d/%0d want 0/0", fwd_a_sel, fwd_b_sel); end
  endtask

  task automatic test_branch;
    do_reset;
    drive(mk(1, 1, 0, 0, 0, 0, 0, 5), 1'b0); tick;   // A writes $5
    drive(mk(1, 1, 0, 0, 0, 0, 0, 6), 1'b0); tick;   // B writes $6
    drive(mk(1, 1, 0, 0, 0, 0, 0, 7), 1'b1);         // C writes $7, branch resolves
    #1;
    n_cmp++; if ({flush_ifid, flush_idex, stall} !== 3'b110) begin n_bad++; $display("FAIL branch_flush: got %b want 110", {flush_ifid, flush_idex, stall}); end
    n_cmp++; if (kill !== 3'b001) begin n_bad++; $display("FAIL branch_kill: got %b want 001", kill); end
    tick;
    drive(mk(1, 1, 0, 1, 1, 6, 7, 8), 1'b0);         // D reads $6 (killed B) and $7 (squashed C)
    #1;
    n_cmp++; if ({flush_ifid, kill} !== '0) begin n_bad++; $display("FAIL branch_one_shot: got %b want 0", {flush_ifid, kill}); end
    n_cmp++; if (flush_count !== 16'd1) begin n_bad++; $display("FAIL branch_count: got %0d want 1", flush_count); end
    tick;
    drive('0, 1'b0);
    #1;
    n_cmp++; if ({fwd_a_sel, fwd_b_sel} !== '0) begin n_bad++; $display("FAIL branch_bubbles: got %0d/%0d want 0/0", fwd_a_sel, fwd_b_sel); end
  endtask

  task automatic test_stall_plus_flush;
    do_reset;
    drive(mk(1, 1, 1, 1, 0, 1, 0, 4), 1'b0); tick;
    drive(mk(1, 1, 0, 1, 1, 4, 4, 5), 1'b1);
    #1;
    n_cmp++; if ({stall, flush_ifid, flush_idex} !== 3'b011) begin n_bad++; $display("FAIL stall_flush_prio: got %b want 011", {stall, flush_ifid, flush_idex}); end
    tick;
    drive('0, 1'b0);
    #1;
    n_cmp++; if ({stall_count, flush_count} !== {16'd0, 16'd1}) begin n_bad++; $display("FAIL stall_flush_counts: got %0d/%0d want 0/1", stall_count, flush_count); end
  endtask

  task automatic test_saturation;
    do_reset;
    repeat (10) begin drive('0, 1'b1); tick; end
    drive('0, 1'b0);
    repeat (9) begin
      drive(mk(1, 1, 1, 1, 0, 1, 0, 4), 1'b0); tick;
      drive(mk(1, 1, 0, 1, 1, 4, 4, 5), 1'b0); tick;
      drive('0, 1'b0); tick;
    end
    #1;
    n_cmp++; if ({s_flush_count, s_stall_count} !== 6'b111111) begin n_bad++; $display("FAIL sat_narrow: got %0d/%0d want 7/7", s_flush_count, s_stall_count); end
    n_cmp++; if ({flush_count, stall_count} !== {16'd10, 16'd9}) begin n_bad++; $display("FAIL sat_wide: got %0d/%0d want 10/9", flush_count, stall_count); end
  endtask

  task automatic test_random;
    instr_t cur;
    logic br, es, held;
    int ea, eb;
    logic [DEPTH-1:0] ek;
    do_reset;
    cur  = '0;
    held = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!held)
        cur = mk($urandom_range(0, 7) != 0, $urandom_range(0, 1), $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      br = ($urandom_range(0, 7) == 0);
      drive(cur, br);
      #1;
      es = m_stall(cur, br);
      ea = m_fwd(hist[0].rs, hist[0].uses_rs);
      eb = m_fwd(hist[0].rt, hist[0].uses_rt);
      ek = '0;
      if (br) for (int s = 1; s <= BR_STAGE - 1; s++) ek[s-1] = 1'b1;
      n_cmp++; if (stall !== es) begin n_bad++; $display("FAIL rnd_stall c=%0d: got %b want %b", c, stall, es); end
      n_cmp++; if ({flush_ifid, flush_idex} !== {br, br}) begin n_bad++; $display("FAIL rnd_flush c=%0d: got %b want %b", c, {flush_ifid, flush_idex}, {br, br}); end
      n_cmp++; if (kill !== ek) begin n_bad++; $display("FAIL rnd_kill c=%0d: got %b want %b", c, kill, ek); end
      n_cmp++; if (fwd_a_sel !== SEL_W'(ea)) begin n_bad++; $display("FAIL rnd_fwd_a c=%0d: got %0d want %0d", c, fwd_a_sel, ea); end
      n_cmp++; if (fwd_b_sel !== SEL_W'(eb)) begin n_bad++; $display("FAIL rnd_fwd_b c=%0d: got %0d want %0d", c, fwd_b_sel, eb); end
      n_cmp++; if ({stall_count, flush_count} !== {CNT_W'(m_stall_cnt), CNT_W'(m_flush_cnt)}) begin n_bad++; $display("FAIL rnd_counts c=%0d: got %0d/%0d want %0d/%0d", c, stall_count, flush_count, m_stall_cnt, m_flush_cnt); end
      m_advance(cur, br, es);
      held = es;
      tick;
    end
  endtask

  initial begin
    test_reset;
    test_alu_chain;
    test_load_use;
    test_zero_and_unused;
    test_branch;
    test_stall_plus_flush;
    test_saturation;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no completion want completion");
    $fatal(1);
  end

endmodule
